// File: rtl/sram_access_seq.sv
// Multi-cycle SRAM access sequencer: accepts one read/write request and drives
// CE/OE/WE timing, captures read data and returns a one-cycle completion pulse.
module sram_access_seq #(
    parameter int unsigned ADDR_W   = 20,
    parameter int unsigned WAIT_CYC = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Req_valid,
    output logic              Req_ready,
    input  logic              Req_we,
    input  logic [ADDR_W-1:0] Req_addr,
    input  logic [15:0]       Req_wdata,
    output logic              Rsp_valid,
    output logic [15:0]       Rsp_rdata,
    output logic [ADDR_W-1:0] ADDR,
    input  logic [15:0]       Data_from_SRAM,
    output logic [15:0]       Data_to_SRAM,
    output logic              Data_oe,
    output logic              Mem_CE,
    output logic              Mem_OE,
    output logic              Mem_WE,
    output logic              Mem_UB,
    output logic              Mem_LB
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = (WAIT_CYC < 2) ? 1 : $clog2(WAIT_CYC + 1);

    generate
        if (WAIT_CYC == 0) begin : g_bad_wait
            $error("sram_access_seq: WAIT_CYC must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   wdata_d;
    logic [DATA_W-1:0]   rdata_d;
    logic                ready_d;
    logic                rsp_valid_d;
    logic                data_oe_d;
    logic                ce_d;
    logic                oe_d;
    logic                we_n_d;

    // Word access only: byte lanes always enabled.
    assign Mem_UB = 1'b0;
    assign Mem_LB = 1'b0;

    // State, datapath and strobe registers.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            ADDR         <= '0;
            Data_to_SRAM <= '0;
            Rsp_rdata    <= '0;
            Req_ready    <= 1'b0;
            Rsp_valid    <= 1'b0;
            Data_oe      <= 1'b0;
            Mem_CE       <= 1'b1;
            Mem_OE       <= 1'b1;
            Mem_WE       <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            ADDR         <= addr_d;
            Data_to_SRAM <= wdata_d;
            Rsp_rdata    <= rdata_d;
            Req_ready    <= ready_d;
            Rsp_valid    <= rsp_valid_d;
            Data_oe      <= data_oe_d;
            Mem_CE       <= ce_d;
            Mem_OE       <= oe_d;
            Mem_WE       <= we_n_d;
        end
    end

    // Next state and next strobe values; strobes are a pure decode of the next
    // state so the registered outputs always match the registered state.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = ADDR;
        wdata_d     = Data_to_SRAM;
        rdata_d     = Rsp_rdata;
        ready_d     = 1'b0;
        rsp_valid_d = 1'b0;
        data_oe_d   = 1'b0;
        ce_d        = 1'b1;
        oe_d        = 1'b1;
        we_n_d      = 1'b1;

        unique case (state_q)
            S_IDLE: begin
                if (Req_valid && Req_ready) begin
                    we_d    = Req_we;
                    addr_d  = Req_addr;
                    wdata_d = Req_wdata;
                    cnt_d   = CNT_W'(WAIT_CYC);
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = S_DONE;
                    if (!we_q) begin
                        rdata_d = Data_from_SRAM;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        unique case (state_d)
            S_IDLE: begin
                ready_d = 1'b1;
            end
            S_SETUP: begin
                ce_d      = 1'b0;
                data_oe_d = we_d;
            end
            S_ACCESS: begin
                ce_d      = 1'b0;
                oe_d      = we_d;
                we_n_d    = !we_d;
                data_oe_d = we_d;
            end
            S_DONE: begin
                ce_d        = 1'b0;
                rsp_valid_d = 1'b1;
                data_oe_d   = we_d;
            end
            default: begin
                ready_d = 1'b0;
            end
        endcase
    end

endmodule
